// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: access-size encodings,
// controller states, request payload and the request error check.
package load_store_unit_pkg;

    localparam int unsigned DATA_WIDTH = 32;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } lsu_state_e;

    // Request fields held for the whole transaction (address kept separately
    // because its width is a parameter of the unit).
    typedef struct packed {
        logic                  write;
        logic [1:0]            size;
        logic                  is_unsigned;
        logic [DATA_WIDTH-1:0] wdata;
    } lsu_req_t;

    // Illegal size always errors; alignment errors only when checking is on.
    function automatic logic req_error(input logic [1:0] size,
                                       input logic [1:0] addr_lo,
                                       input logic       check_align);
        logic bad;
        bad = (size == 2'b11);
        if (check_align) begin
            if (size == SIZE_HALF && addr_lo[0])        bad = 1'b1;
            if (size == SIZE_WORD && addr_lo != 2'b00)  bad = 1'b1;
        end
        return bad;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response handshake and memory-side signals of the load/store unit.
//   slave  : view taken by load_store_unit
//   master : view taken by the pipeline stage plus main memory
interface load_store_unit_if #(
    parameter int unsigned ADDR_WIDTH = 32
);
    import load_store_unit_pkg::*;

    logic                  reqValid;
    logic                  reqReady;
    logic                  reqWrite;
    logic [1:0]            reqSize;
    logic                  reqUnsigned;
    logic [ADDR_WIDTH-1:0] reqAddress;
    logic [DATA_WIDTH-1:0] reqWriteData;

    logic                  respValid;
    logic                  respReady;
    logic [DATA_WIDTH-1:0] respReadData;
    logic                  respError;

    logic [ADDR_WIDTH-1:0] memAddress;
    logic                  memReadEnable;
    logic                  memWriteEnable;
    logic [DATA_WIDTH-1:0] memWriteData;
    logic [DATA_WIDTH-1:0] memReadData;

    modport slave (
        input  reqValid, reqWrite, reqSize, reqUnsigned, reqAddress, reqWriteData,
        input  respReady, memReadData,
        output reqReady, respValid, respReadData, respError,
        output memAddress, memReadEnable, memWriteEnable, memWriteData
    );

    modport master (
        output reqValid, reqWrite, reqSize, reqUnsigned, reqAddress, reqWriteData,
        output respReady, memReadData,
        input  reqReady, respValid, respReadData, respError,
        input  memAddress, memReadEnable, memWriteEnable, memWriteData
    );

endinterface

// File: rtl/load_store_unit_data_align.sv
// Combinational data steering for big-endian sub-word accesses.
//   size, is_unsigned : access size and zero-extend select
//   read_word         : memory word starting at the access address
//   store_data        : right-aligned store data
//   load_data         : extracted and extended load result
//   merged_data       : store data placed in the top bytes, rest from read_word
module lsu_data_align
    import load_store_unit_pkg::*;
(
    input  logic [1:0]            size,
    input  logic                  is_unsigned,
    input  logic [DATA_WIDTH-1:0] read_word,
    input  logic [DATA_WIDTH-1:0] store_data,
    output logic [DATA_WIDTH-1:0] load_data,
    output logic [DATA_WIDTH-1:0] merged_data
);

    logic fill;

    // The addressed byte is the most significant one of the read word.
    always_comb begin
        load_data   = read_word;
        merged_data = store_data;
        fill        = 1'b0;
        case (size)
            SIZE_BYTE: begin
                fill        = !is_unsigned && read_word[31];
                load_data   = {{24{fill}}, read_word[31:24]};
                merged_data = {store_data[7:0], read_word[23:0]};
            end
            SIZE_HALF: begin
                fill        = !is_unsigned && read_word[31];
                load_data   = {{16{fill}}, read_word[31:16]};
                merged_data = {store_data[15:0], read_word[15:0]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns byte/halfword/word requests into single-word memory
// cycles, using read-modify-write for sub-word stores. One transaction at a time.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : request/response handshake and memory port (slave view)
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter bit          CHECK_ALIGN = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    load_store_unit_if.slave  bus
);

    lsu_state_e            state_q, state_d;
    lsu_req_t              req_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic                  accept_c;
    logic                  req_err_c;
    logic [DATA_WIDTH-1:0] load_data_c;
    logic [DATA_WIDTH-1:0] merged_c;

    assign accept_c  = (state_q == IDLE) && bus.reqValid;
    assign req_err_c = req_error(bus.reqSize, bus.reqAddress[1:0], CHECK_ALIGN);

    lsu_data_align u_align (
        .size        (req_q.size),
        .is_unsigned (req_q.is_unsigned),
        .read_word   (rdata_q),
        .store_data  (req_q.wdata),
        .load_data   (load_data_c),
        .merged_data (merged_c)
    );

    // State, captured request and read-data registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            req_q   <= '0;
            addr_q  <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept_c) begin
                req_q.write       <= bus.reqWrite;
                req_q.size        <= bus.reqSize;
                req_q.is_unsigned <= bus.reqUnsigned;
                req_q.wdata       <= bus.reqWriteData;
                addr_q            <= bus.reqAddress;
                err_q             <= req_err_c;
            end
            if (state_q == READ) rdata_q <= bus.memReadData;
        end
    end

    // Next state and state-decoded outputs; enables come straight from state
    // so an asynchronous reset removes a pending write immediately.
    always_comb begin
        state_d            = state_q;
        bus.reqReady       = 1'b0;
        bus.respValid      = 1'b0;
        bus.respReadData   = '0;
        bus.respError      = 1'b0;
        bus.memReadEnable  = 1'b0;
        bus.memWriteEnable = 1'b0;
        bus.memAddress     = '0;
        bus.memWriteData   = '0;
        case (state_q)
            IDLE: begin
                bus.reqReady = 1'b1;
                if (bus.reqValid) begin
                    if (req_err_c)                      state_d = RESP;
                    else if (!bus.reqWrite)             state_d = READ;
                    else if (bus.reqSize == SIZE_WORD)  state_d = WRITE;
                    else                                state_d = READ;
                end
            end
            READ: begin
                bus.memReadEnable = 1'b1;
                bus.memAddress    = addr_q;
                state_d           = req_q.write ? WRITE : RESP;
            end
            WRITE: begin
                bus.memWriteEnable = 1'b1;
                bus.memAddress     = addr_q;
                bus.memWriteData   = merged_c;
                state_d            = RESP;
            end
            RESP: begin
                bus.respValid = 1'b1;
                bus.respError = err_q;
                if (!err_q && !req_q.write) bus.respReadData = load_data_c;
                if (bus.respReady) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the pipeline memory stage and the byte-addressed main memory (combinational big-endian 32-bit read at any byte address, synchronous 4-byte write when write enable is high and read enable is low).
- Converts byte, halfword and word load/store requests into memory cycles.
- Sub-word stores use read-modify-write. Loads are sign- or zero-extended.
- Request and response use a valid/ready handshake. One transaction is in flight at a time.

Parameters:
- ADDR_WIDTH, 32, byte address width; must match main memory.
- CHECK_ALIGN, 1, 1 = misaligned halfword/word requests return an error; 0 = pass through unchecked.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- reqValid  in  1  request valid
- reqReady  out  1  unit can accept a request
- reqWrite  in  1  1 = store, 0 = load
- reqSize  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- reqUnsigned  in  1  load zero-extends when 1; ignored for stores
- reqAddress  in  ADDR_WIDTH  byte address
- reqWriteData  in  32  store data, right-aligned (byte in [7:0], halfword in [15:0])
- respValid  out  1  response valid
- respReady  in  1  consumer accepts response
- respReadData  out  32  extended load data; 0 for stores and errors
- respError  out  1  misaligned or illegal-size request
- memAddress  out  ADDR_WIDTH  to memory address
- memReadEnable  out  1  to memory readEnable
- memWriteEnable  out  1  to memory writeEnable
- memWriteData  out  32  to memory dataIn
- memReadData  in  32  from memory dataOut

Behaviour:
- States: IDLE, READ, WRITE, RESP. Registered state; all outputs are decoded from state plus registered request fields.
- Reset: state=IDLE, respValid=0, respReadData=0, respError=0, memReadEnable=0, memWriteEnable=0, memAddress=0, memWriteData=0, captured request and read registers cleared.
- reqReady=1 exactly in IDLE. A request is accepted on the edge where reqValid & reqReady. Address, size, write, unsigned and data are captured on that edge.
- Error check at accept:
  - reqSize==11 is always an error.
  - With CHECK_ALIGN=1, halfword with address[0]!=0 is an error, and word with address[1:0]!=0 is an error.
  - Error goes IDLE→RESP with respError=1, respReadData=0, and no memory enable ever asserted.
- Load: IDLE→READ→RESP.
  - In READ: memReadEnable=1, memWriteEnable=0, memAddress=captured address.
  - memReadData is registered at the end of READ.
  - Extraction (big-endian, memory word = bytes A..A+3): byte = [31:24], halfword = [31:16], word = all 32 bits.
  - Sign-extend unless reqUnsigned.
- Word store: IDLE→WRITE→RESP.
  - In WRITE: memWriteEnable=1, memReadEnable=0, memWriteData=reqWriteData.
- Byte/halfword store: IDLE→READ→WRITE→RESP.
  - The READ capture is merged in WRITE: byte puts reqWriteData[7:0] into [31:24]; halfword puts reqWriteData[15:0] into [31:16].
  - The remaining bits equal the captured read value, so bytes A+1..A+3 are rewritten unchanged.
- memReadEnable and memWriteEnable are never high in the same cycle. Both are 0 in IDLE and RESP.
- RESP: respValid=1; data and error are held stable until respReady. On respValid & respReady: go to IDLE, respValid=0.
- A new request can be accepted no earlier than the cycle after the response handshake. There is no bypass.
- Latency in edges from accept to respValid high: error 1, load 2, word store 2, sub-word store 3. Each extra cycle respReady is low adds one cycle.
- Address arithmetic is modulo 2^ADDR_WIDTH.
  - A byte access at 0xFFFFFFFF RMWs bytes FFFFFFFF,0,1,2. Only FFFFFFFF changes.
- Reset mid-operation:
  - Asserting reset during WRITE drops memWriteEnable combinationally from state, so no write occurs at any edge where reset is high.
  - Transaction state is discarded and no response is produced.
- reqValid while not in IDLE is ignored (not captured).

Decomposition:
- Shared package holds:
  - size encodings (SIZE_BYTE=2'b00, SIZE_HALF=2'b01, SIZE_WORD=2'b10).
  - state enum (IDLE, READ, WRITE, RESP).
  - DATA_WIDTH=32.
- One natural sub-module: lsu_data_align.
  - Combinational.
  - Does load extraction with sign/zero extension and store merge by size.
  - Shared by the unit and the bench's reference model.

Test Plan:
- Preload bytes 0x100..0x103 = 80 12 34 56; LW 0x100 → respReadData=0x80123456, respError=0, respValid on 2nd edge after accept.
- Same memory; LB 0x100 signed → 0xFFFFFF80; LBU → 0x00000080; LH 0x102 signed → 0x00003456; LH 0x100 → 0xFFFF8012.
- SB 0xAB at 0x101 (bytes 0x100..0x104 = 80 12 34 56 77) → memory 80 AB 34 56 77; one READ cycle, then one WRITE cycle; respValid on 3rd edge; enables never overlap.
- LW 0x102 with CHECK_ALIGN=1 → respError=1, respReadData=0, no memReadEnable/memWriteEnable pulse; reqSize=11 at 0x100 → respError=1.
- SW 0xDEADBEEF at 0x200 with respReady held low 5 cycles → respValid held, reqReady=0 throughout, reqValid pulses ignored; LW 0x200 afterwards → 0xDEADBEEF.
- Assert reset during the WRITE cycle of SH 0x1234 at 0x300 (old word 0xCAFEF00D) → no write occurs; memory still 0xCAFEF00D; all outputs at reset values; state IDLE; reqReady=1 after release.
